// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: transition-minimising stage, then DC-balancing stage.
// Define TMDS_TALLY_OUT_EN to expose the running disparity on tally_out.
module tmds_encoder (
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic [1:0] control_in,
   input  logic       ve_in,
   output logic [9:0] tmds_out
`ifdef TMDS_TALLY_OUT_EN
   ,
   output logic [4:0] tally_out
`endif
);

   logic [8:0] q_m;
   logic       ve_s1;
   logic [1:0] control_s1;
   logic [4:0] tally;

   logic [3:0] n1_d;
   logic       use_xnor;
   logic [8:0] q_m_d;

   always_comb begin
      n1_d = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n1_d = n1_d + {3'b000, data_in[i]};
      end
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data_in[0]);
      q_m_d    = 9'd0;
      q_m_d[0] = data_in[0];
      for (int i = 1; i < 8; i++) begin
         q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_in[i]) : (q_m_d[i-1] ^ data_in[i]);
      end
      q_m_d[8] = ~use_xnor;
   end

   logic [3:0] n1_q;
   logic [4:0] diff;
   logic       tally_zero;
   logic       tally_neg;
   logic       q8;
   logic [9:0] sym_nx;
   logic [4:0] tally_nx;

   always_comb begin
      n1_q = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n1_q = n1_q + {3'b000, q_m[i]};
      end
      // N1 - N0 as 5-bit two's complement: 2*N1 - 8
      diff       = {n1_q, 1'b0} - 5'd8;
      tally_zero = (tally == 5'd0);
      tally_neg  = tally[4];
      q8         = q_m[8];
      sym_nx     = 10'd0;
      tally_nx   = 5'd0;
      if (!ve_s1) begin
         case (control_s1)
            2'b00:   sym_nx = 10'b1101010100;
            2'b01:   sym_nx = 10'b0010101011;
            2'b10:   sym_nx = 10'b0101010100;
            default: sym_nx = 10'b1010101011;
         endcase
         tally_nx = 5'd0;
      end else if (tally_zero || (n1_q == 4'd4)) begin
         sym_nx   = {~q8, q8, (q8 ? q_m[7:0] : ~q_m[7:0])};
         tally_nx = q8 ? (tally + diff) : (tally - diff);
      end else if ((!tally_neg && (n1_q > 4'd4)) || (tally_neg && (n1_q < 4'd4))) begin
         sym_nx   = {1'b1, q8, ~q_m[7:0]};
         tally_nx = tally + {3'b000, q8, 1'b0} - diff;
      end else begin
         sym_nx   = {1'b0, q8, q_m[7:0]};
         tally_nx = tally + diff - {3'b000, ~q8, 1'b0};
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         q_m        <= 9'd0;
         ve_s1      <= 1'b0;
         control_s1 <= 2'b00;
         tally      <= 5'd0;
         tmds_out   <= 10'd0;
      end else begin
         q_m        <= q_m_d;
         ve_s1      <= ve_in;
         control_s1 <= control_in;
         tally      <= tally_nx;
         tmds_out   <= sym_nx;
      end
   end

`ifdef TMDS_TALLY_OUT_EN
   assign tally_out = tally;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed scenarios, reset handling and a random active line.
module tb_tmds_encoder;

   logic       pixel_clk;
   logic       rst;
   logic [7:0] data_in;
   logic [1:0] control_in;
   logic       ve_in;
   logic [9:0] tmds_out;
`ifdef TMDS_TALLY_OUT_EN
   logic [4:0] tally_out;
`endif

   tmds_encoder dut (
      .pixel_clk  (pixel_clk),
      .rst        (rst),
      .data_in    (data_in),
      .control_in (control_in),
      .ve_in      (ve_in),
      .tmds_out   (tmds_out)
`ifdef TMDS_TALLY_OUT_EN
      ,
      .tally_out  (tally_out)
`endif
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic [9:0] sym;
      logic [4:0] tal;
      bit         rng;
   } exp_t;

   exp_t sb[$];
   int   m_tally;
   int   n_chk;
   int   n_bad;

   task automatic model(input logic v, input logic [1:0] c, input logic [7:0] d,
                        inout int t, output logic [9:0] sym);
      int         ones, n1, n0;
      bit         xn;
      logic [7:0] q;
      logic       q8;
      ones = $countones(d);
      xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? !(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q8 = !xn;
      n1 = $countones(q);
      n0 = 8 - n1;
      if (!v) begin
         case (c)
            2'b00: sym = 10'h354;
            2'b01: sym = 10'h0AB;
            2'b10: sym = 10'h154;
            default: sym = 10'h2AB;
         endcase
         t = 0;
      end else if (t == 0 || n1 == n0) begin
         if (q8) begin sym = {2'b01, q};  t = t + (n1 - n0); end
         else    begin sym = {2'b10, ~q}; t = t + (n0 - n1); end
      end else if ((t > 0 && n1 > n0) || (t < 0 && n0 > n1)) begin
         sym = {1'b1, q8, ~q};
         t   = t + 2 * int'(q8) + (n0 - n1);
      end else begin
         sym = {1'b0, q8, q};
         t   = t + (n1 - n0) - 2 * (1 - int'(q8));
      end
   endtask

   task automatic tick(input logic r, input logic v, input logic [1:0] c, input logic [7:0] d,
                       input bit ovr, input logic [9:0] osym, input logic [4:0] otal, input bit rng);
      exp_t       e, x;
      logic [9:0] s;
      logic [4:0] tv;
      @(posedge pixel_clk);
      #1;
      if (sb.size() >= 2) begin
         x  = sb.pop_front();
         tv = dut.tally;
         n_chk++;
         assert (tmds_out === x.sym) else begin
            n_bad++;
            $error("FAIL symbol: tmds_out=%h expected %h", tmds_out, x.sym);
         end
         n_chk++;
         assert (tv === x.tal) else begin
            n_bad++;
            $error("FAIL tally: tally=%h expected %h", tv, x.tal);
         end
         if (x.rng) begin
            n_chk++;
            assert ($signed(tv) >= -8 && $signed(tv) <= 8) else begin
               n_bad++;
               $error("FAIL tally_range: tally=%0d expected within -8..8", $signed(tv));
            end
         end
      end
      rst        = r;
      ve_in      = v;
      control_in = c;
      data_in    = d;
      if (r) begin
         // the symbol still in stage 1 is flushed by this reset
         if (sb.size() > 0) begin
            x     = sb.pop_back();
            x.sym = 10'd0;
            x.tal = 5'd0;
            x.rng = 1'b0;
            sb.push_back(x);
         end
         m_tally = 0;
         e.sym   = 10'h354;
         e.tal   = 5'd0;
         e.rng   = 1'b0;
      end else begin
         model(v, c, d, m_tally, s);
         e.sym = s;
         e.tal = m_tally[4:0];
         e.rng = rng;
      end
      if (ovr) begin
         e.sym = osym;
         e.tal = otal;
      end
      sb.push_back(e);
   endtask

   initial begin
      n_chk      = 0;
      n_bad      = 0;
      m_tally    = 0;
      rst        = 1'b1;
      ve_in      = 1'b0;
      control_in = 2'b00;
      data_in    = 8'h00;

      repeat (3) tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 10'h000, 5'h00, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 10'h354, 5'h00, 1'b0);

      tick(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h100, 5'h18, 1'b0);
      tick(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h3FF, 5'h02, 1'b0);
      tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 10'h354, 5'h00, 1'b0);
      tick(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 10'h200, 5'h18, 1'b0);

      tick(1'b0, 1'b0, 2'b00, 8'hA5, 1'b1, 10'h354, 5'h00, 1'b0);
      tick(1'b0, 1'b0, 2'b01, 8'hA5, 1'b1, 10'h0AB, 5'h00, 1'b0);
      tick(1'b0, 1'b0, 2'b10, 8'hA5, 1'b1, 10'h154, 5'h00, 1'b0);
      tick(1'b0, 1'b0, 2'b11, 8'hA5, 1'b1, 10'h2AB, 5'h00, 1'b0);

      // mid-line reset while tally is -8
      tick(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h100, 5'h18, 1'b0);
      tick(1'b0, 1'b1, 2'b00, 8'h55, 1'b0, 10'h000, 5'h00, 1'b0);
      tick(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 10'h000, 5'h00, 1'b0);
      tick(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h100, 5'h18, 1'b0);

      repeat (2) tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 10'h000, 5'h00, 1'b0);
      for (int i = 0; i < 640; i++)
         tick(1'b0, 1'b1, 2'b00, 8'($urandom_range(0, 255)), 1'b0, 10'h000, 5'h00, 1'b1);
      repeat (4) tick(1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 10'h000, 5'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have port pixel_clk  input  1  pixel clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port data_in  input  8  pixel colour byte for this channel.
REQ-005 The block SHALL have port control_in  input  2  control bits; {v_sync,h_sync} on the blue channel, 2'b00 otherwise.
REQ-006 The block SHALL have port ve_in  input  1  video enable, driven from active_draw.
REQ-007 The block SHALL have port tmds_out  output  10  encoded TMDS symbol, registered.
REQ-008 The block SHALL use one clock, pixel_clk; reset rst SHALL be synchronous and active-high.

Function
REQ-009 The block SHALL be a 2-stage pipeline: inputs sampled at edge N SHALL appear on tmds_out after edge N+2; data, control and ve paths SHALL be equally delayed.
REQ-010 Stage 1 SHALL register q_m[8:0], ve_s1 and control_s1.
REQ-011 q_m[0] SHALL equal data_in[0].
REQ-012 Stage 1 SHALL use the XNOR chain (q_m[i] = ~(q_m[i-1]^data_in[i]), i=1..7, q_m[8]=0) when the count of ones in data_in is greater than 4, or equal to 4 with data_in[0]=0.
REQ-013 Otherwise stage 1 SHALL use the XOR chain (q_m[i] = q_m[i-1]^data_in[i], q_m[8]=1).
REQ-014 Stage 2 SHALL hold a 5-bit two's-complement running disparity register tally, range -16..+15; overflow is not reachable with legal TMDS data.
REQ-015 Stage 2 SHALL compute N1 = ones in q_m[7:0] and N0 = 8-N1.
REQ-016 When ve_s1=0, tmds_out SHALL take the control token: 00->10'b1101010100, 01->10'b0010101011, 10->10'b0101010100, 11->10'b1010101011.
REQ-017 When ve_s1=0, tally SHALL be cleared to 0.
REQ-018 When ve_s1=1 and (tally==0 or N1==N0), tmds_out SHALL be {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
REQ-019 In the REQ-018 case, tally SHALL add (N0-N1) if q_m[8]=0, else (N1-N0).
REQ-020 When ve_s1=1 and ((tally>0 and N1>N0) or (tally<0 and N0>N1)), tmds_out SHALL be {1, q_m[8], ~q_m[7:0]}.
REQ-021 In the REQ-020 case, tally SHALL add 2*q_m[8] + (N0-N1).
REQ-022 When ve_s1=1 and neither REQ-018 nor REQ-020 applies, tmds_out SHALL be {0, q_m[8], q_m[7:0]}.
REQ-023 In the REQ-022 case, tally SHALL add (N1-N0) - 2*(~q_m[8]).
REQ-024 Transitions of ve_in between data and blanking SHALL take effect on exactly the symbol for which ve_in changed, with no gap or duplicate symbol.

Reset
REQ-025 While rst=1 at a clock edge, q_m, ve_s1, control_s1, tally and tmds_out SHALL all become 0.
REQ-026 The first valid symbol after rst deasserts at edge R SHALL be the one for inputs sampled at edge R+1, appearing after edge R+3.
REQ-027 Reset asserted mid-stream SHALL discard in-flight symbols; tally SHALL restart from 0.

Configuration
REQ-028 With macro TMDS_TALLY_OUT_EN defined, the block SHALL add port tally_out  output  5  equal to the current tally register, for debug and verification.
REQ-029 Without TMDS_TALLY_OUT_EN, the tally_out port SHALL be absent and encoding behaviour SHALL be identical.

Verification
REQ-030 Scenario: after reset, ve_in=1, data_in=8'h00 -> tmds_out=10'h100 two cycles later, tally=-8.
REQ-031 Scenario: next consecutive data_in=8'h00 -> tmds_out=10'h3FF, tally=+2.
REQ-032 Scenario: from tally=0, ve_in=1, data_in=8'hFF -> tmds_out=10'h200, tally=-8.
REQ-033 Scenario: ve_in=0 with control_in sequenced 00,01,10,11 -> tmds_out 10'h354, 10'h0AB, 10'h154, 10'h2AB two cycles later each, tally=0.
REQ-034 Scenario: rst asserted for one cycle while tally=-8 mid-active-line -> tmds_out=0 and tally=0 after that edge; the next data_in=8'h00 again yields 10'h100.
REQ-035 Scenario: random data over a full active line, checked against a reference model -> all symbols match, and tally stays within -8..+8.
